// File: rtl/div16u_if.sv
// Handshake and operand/result bundle for the 16-by-8 sequential divider.
interface div16u_if;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        ready;
   logic        busy;
   logic        div_by_zero;

   // Requester side: issues operands and start, observes results.
   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, ready, busy, div_by_zero
   );

   // Divider side.
   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, ready, busy, div_by_zero
   );
endinterface

// File: rtl/div16u_seq.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per cycle (MSB first).
module div16u_seq (
   input  logic    clk,
   input  logic    rst,
   div16u_if.slave bus
);

   localparam int unsigned DW = 16;
   localparam int unsigned VW = 8;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [DW-1:0]  dvd_q;       // dividend, shifted left so bit DW-1 is the next bit to bring down
   logic [VW-1:0]  dvs_q;
   logic [VW-1:0]  partial;     // partial remainder; always < divisor so 8 bits suffice between steps
   logic [DW-1:0]  q_sh;
   logic [CW-1:0]  count;

   logic           accept_c;
   logic           last_c;
   logic [VW:0]    trial_c;
   logic [VW:0]    diff_c;
   logic           qbit_c;
   logic [VW-1:0]  part_nxt_c;

   // Next-state and one restoring step of the datapath.
   always_comb begin
      state_nxt  = state;
      accept_c   = 1'b0;
      last_c     = 1'b0;
      trial_c    = {partial, dvd_q[DW-1]};
      diff_c     = trial_c - {1'b0, dvs_q};
      qbit_c     = ~diff_c[VW];
      part_nxt_c = qbit_c ? diff_c[VW-1:0] : trial_c[VW-1:0];

      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               accept_c  = 1'b1;
               state_nxt = (bus.divisor == VW'(0)) ? DONE : RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            if (count == CW'(DW - 1)) begin
               last_c    = 1'b1;
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         dvd_q           <= '0;
         dvs_q           <= '0;
         partial         <= '0;
         q_sh            <= '0;
         count           <= '0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.ready       <= 1'b0;
         bus.busy        <= 1'b0;
         bus.div_by_zero <= 1'b0;
      end else begin
         state     <= state_nxt;
         bus.ready <= (state_nxt == DONE);
         bus.busy  <= (state_nxt == RUN);

         if (accept_c) begin
            dvd_q   <= bus.dividend;
            dvs_q   <= bus.divisor;
            partial <= '0;
            q_sh    <= '0;
            count   <= '0;
            if (bus.divisor == VW'(0)) begin
               bus.quotient    <= '1;
               bus.remainder   <= '1;
               bus.div_by_zero <= 1'b1;
            end else begin
               bus.div_by_zero <= 1'b0;
            end
         end else if (state == RUN) begin
            dvd_q   <= {dvd_q[DW-2:0], 1'b0};
            partial <= part_nxt_c;
            q_sh    <= {q_sh[DW-2:0], qbit_c};
            count   <= count + CW'(1);
            if (last_c) begin
               bus.quotient  <= {q_sh[DW-2:0], qbit_c};
               bus.remainder <= part_nxt_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_div16u_seq.sv
// Directed self-checking bench for div16u_seq.
module tb_div16u_seq;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   div16u_if bus ();

   div16u_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse start with operands, then wait (bounded) for ready; lat = edges from accept to ready.
   task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                          output int lat, output logic busy_first, output int busy_hits);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = 16'hBEEF;
      bus.divisor  = 8'hA5;
      lat        = -1;
      busy_hits  = 0;
      busy_first = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) busy_first = bus.busy;
         if (bus.busy) busy_hits++;
         if (bus.ready) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int pulses;
      rst       = 1'b1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      pulses = 0;
      @(negedge clk);
      total++; if (bus.quotient !== 16'h0) begin bad++; $display("FAIL reset_quotient got=%h want=0000", bus.quotient); end
      total++; if (bus.remainder !== 8'h0) begin bad++; $display("FAIL reset_remainder got=%h want=00", bus.remainder); end
      total++; if ({bus.ready, bus.busy, bus.div_by_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {bus.ready, bus.busy, bus.div_by_zero}); end
      repeat (4) begin @(negedge clk); if (bus.ready) pulses++; end
      total++; if (pulses != 0) begin bad++; $display("FAIL reset_no_ready got=%0d want=0", pulses); end
   endtask

   task automatic test_basic();
      int lat, bh;
      logic bf;
      run_div(16'd45, 8'd3, lat, bf, bh);
      total++; if (lat != 17) begin bad++; $display("FAIL basic_latency got=%0d want=17", lat); end
      total++; if (bf !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bf); end
      total++; if (bus.quotient !== 16'd15 || bus.remainder !== 8'd0 || bus.div_by_zero !== 1'b0) begin
         bad++; $display("FAIL basic_result got=%0d r %0d z %b want=15 r 0 z 0", bus.quotient, bus.remainder, bus.div_by_zero); end
      @(negedge clk);
      total++; if ({bus.ready, bus.busy} !== 2'b00) begin bad++; $display("FAIL basic_after got=%b want=00", {bus.ready, bus.busy}); end
      repeat (3) @(negedge clk);
      total++; if (bus.quotient !== 16'd15 || bus.remainder !== 8'd0) begin bad++; $display("FAIL basic_hold got=%0d r %0d want=15 r 0", bus.quotient, bus.remainder); end
   endtask

   task automatic test_vectors();
      logic [15:0] va [3] = '{16'd65025, 16'd1000, 16'd65535};
      logic [7:0]  vb [3] = '{8'd255,    8'd7,     8'd1};
      logic [15:0] vq [3] = '{16'd255,   16'd142,  16'd65535};
      logic [7:0]  vr [3] = '{8'd0,      8'd6,     8'd0};
      int lat, bh;
      logic bf;
      for (int i = 0; i < 3; i++) begin
         run_div(va[i], vb[i], lat, bf, bh);
         total++; if (lat != 17) begin bad++; $display("FAIL vec%0d_latency got=%0d want=17", i, lat); end
         total++; if (bus.quotient !== vq[i] || bus.remainder !== vr[i]) begin
            bad++; $display("FAIL vec%0d_result got=%0d r %0d want=%0d r %0d", i, bus.quotient, bus.remainder, vq[i], vr[i]); end
      end
   endtask

   task automatic test_div_zero();
      int lat, bh;
      logic bf;
      run_div(16'd1234, 8'd0, lat, bf, bh);
      total++; if (lat != 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
      total++; if (bh != 0) begin bad++; $display("FAIL dz_busy got=%0d want=0", bh); end
      total++; if (bus.quotient !== 16'hFFFF || bus.remainder !== 8'hFF || bus.div_by_zero !== 1'b1) begin
         bad++; $display("FAIL dz_result got=%h r %h z %b want=ffff r ff z 1", bus.quotient, bus.remainder, bus.div_by_zero); end
      @(negedge clk);
      total++; if (bus.ready !== 1'b0 || bus.div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_after got=%b%b want=01", bus.ready, bus.div_by_zero); end
      run_div(16'd100, 8'd9, lat, bf, bh);
      total++; if (lat != 17) begin bad++; $display("FAIL dz_next_latency got=%0d want=17", lat); end
      total++; if (bus.quotient !== 16'd11 || bus.remainder !== 8'd1 || bus.div_by_zero !== 1'b0) begin
         bad++; $display("FAIL dz_next_result got=%0d r %0d z %b want=11 r 1 z 0", bus.quotient, bus.remainder, bus.div_by_zero); end
   endtask

   task automatic test_back_to_back();
      int lat, pulses;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 16'd100;
      bus.divisor  = 8'd9;
      @(posedge clk);
      #1;
      bus.dividend = 16'd50;
      bus.divisor  = 8'd5;
      lat = -1; pulses = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.ready) begin pulses++; lat = n; break; end
      end
      total++; if (lat != 17 || pulses != 1) begin bad++; $display("FAIL b2b_first got=lat %0d pulses %0d want=lat 17 pulses 1", lat, pulses); end
      total++; if (bus.quotient !== 16'd11 || bus.remainder !== 8'd1) begin
         bad++; $display("FAIL b2b_first_result got=%0d r %0d want=11 r 1", bus.quotient, bus.remainder); end
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      total++; if ({bus.ready, bus.busy} !== 2'b01) begin bad++; $display("FAIL b2b_rearm got=%b want=01", {bus.ready, bus.busy}); end
      lat = -1;
      for (int n = 2; n <= 40; n++) begin
         @(negedge clk);
         if (bus.ready) begin lat = n; break; end
      end
      total++; if (lat != 17) begin bad++; $display("FAIL b2b_second_latency got=%0d want=17", lat); end
      total++; if (bus.quotient !== 16'd10 || bus.remainder !== 8'd0) begin
         bad++; $display("FAIL b2b_second_result got=%0d r %0d want=10 r 0", bus.quotient, bus.remainder); end
   endtask

   task automatic test_reset_mid();
      int lat, bh, pulses;
      logic bf;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 16'd1000;
      bus.divisor  = 8'd7;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (bus.quotient !== 16'h0 || bus.remainder !== 8'h0 || {bus.ready, bus.busy, bus.div_by_zero} !== 3'b000) begin
         bad++; $display("FAIL midrst_outputs got=%0d r %0d flags %b want=0 r 0 flags 000", bus.quotient, bus.remainder, {bus.ready, bus.busy, bus.div_by_zero}); end
      pulses = 0;
      repeat (20) begin @(negedge clk); if (bus.ready || bus.busy) pulses++; end
      total++; if (pulses != 0) begin bad++; $display("FAIL midrst_idle got=%0d want=0", pulses); end
      run_div(16'd1000, 8'd7, lat, bf, bh);
      total++; if (lat != 17 || bus.quotient !== 16'd142 || bus.remainder !== 8'd6) begin
         bad++; $display("FAIL midrst_fresh got=lat %0d %0d r %0d want=lat 17 142 r 6", lat, bus.quotient, bus.remainder); end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = 16'h0;
      bus.divisor  = 8'h0;
      test_reset();
      test_basic();
      test_vectors();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div16u_seq.md
# div16u_seq

Sequential unsigned 16-by-8 restoring divider placed directly downstream of the 8-bit sequential multiplier. It consumes a 16-bit product as the dividend and an 8-bit divisor, and produces a 16-bit quotient and an 8-bit remainder. Each iteration resolves one quotient bit, so 16 iterations complete a division. A start/ready handshake allows the block to chain onto the multiplier's completion.

## Interface
No parameters; all widths are fixed.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new division; sampled on the rising edge
- dividend  in  16  unsigned dividend, typically a multiplier product
- divisor  in  8  unsigned divisor
- quotient  out  16  unsigned quotient; registered
- remainder  out  8  unsigned remainder; registered
- ready  out  1  one-cycle pulse marking valid results
- busy  out  1  high while an iteration is in progress
- div_by_zero  out  1  set with results when the latched divisor was 0

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE:
  - With start=1, latch dividend and divisor into internal registers.
  - If divisor≠0: clear the 9-bit partial remainder, set iteration count=0, go to RUN.
  - If divisor=0: go straight to DONE with quotient=16'hFFFF, remainder=8'hFF, div_by_zero=1.
- RUN, once per cycle (restoring division, MSB first):
  - Form the trial value {partial[7:0], dividend_reg[15-count]} as 9 bits, then subtract {1'b0, divisor_reg}.
  - If the result is non-negative, keep the difference and shift a 1 into the quotient. Otherwise keep the trial value and shift a 0 into the quotient.
  - Increment count. After count 15 is processed, go to DONE.
- DONE:
  - Drive quotient and remainder (partial[7:0]) from the final values; assert ready for exactly this cycle.
  - Next edge: go to IDLE, or go to RUN if start=1 (back-to-back accept, with new operands latched).
- quotient, remainder and div_by_zero hold their values until the next accepted start. div_by_zero clears on any accepted start whose divisor is non-zero.
- A start asserted while in RUN is ignored; operands are not relatched.
- Arithmetic: partial remainder is 9 bits wide to cover the subtract borrow. The final remainder always fits in 8 bits because it is less than the divisor, which is at most 255.
- Reset in any state, including mid-RUN:
  - Next state IDLE.
  - All outputs 0: quotient=0, remainder=0, ready=0, busy=0, div_by_zero=0.
  - Internal count and partial remainder cleared; an in-flight division is discarded.

## Timing
- Edge E0 accepts start with a non-zero divisor. busy=1 from E0 through E16, the 16 RUN edges E1..E16.
- After E16: state=DONE, ready=1 and results valid. Latency from start edge to ready is 17 cycles.
- After E17: ready=0, busy=0. Results are stable from E16 until the next accept.
- Divide by zero: start accepted at E0 gives DONE after E0, so ready=1 in the next cycle (latency 1). busy is never asserted.
- Back-to-back: start=1 during DONE is accepted at E17. busy=1 from E17 and the second ready follows 17 cycles later. No IDLE cycle is required between divisions.
- Inputs are sampled only on the accepting edge; they may change freely during RUN.

## Test plan
- Reset held 2 cycles, then released with start=0 -> all outputs 0, busy=0, no ready pulse.
- dividend=45, divisor=3, one-cycle start -> after 17 cycles ready pulses once; quotient=15, remainder=0, div_by_zero=0.
- dividend=65025, divisor=255 -> quotient=255, remainder=0. dividend=1000, divisor=7 -> quotient=142, remainder=6. dividend=65535, divisor=1 -> quotient=65535, remainder=0.
- dividend=1234, divisor=0 -> ready one cycle after start; quotient=16'hFFFF, remainder=8'hFF, div_by_zero=1. A following 100/9 -> quotient=11, remainder=1, div_by_zero=0.
- Start 100/9 with start held high; change operands to 50/5 during RUN -> a single result (11 r 1); the next result (10 r 0) appears only via back-to-back accept in DONE.
- Assert rst at RUN cycle 8 of 1000/7 -> next cycle all outputs 0, state IDLE. A fresh start afterwards yields correct results with no leftover state.
